// File: rtl/riscv_storebuffer.sv
// Store buffer: aligns and lane-shifts committed stores, queues them in a small
// FIFO, drains to the data-memory write port and flags loads hitting pending stores.
module riscv_storebuffer #(
  parameter int width = 64,
  parameter int DEPTH = 4
) (
  input  logic             i_riscv_stbuf_clk,
  input  logic             i_riscv_stbuf_rst,
  input  logic             i_riscv_stbuf_valid,
  input  logic [width-1:0] i_riscv_stbuf_addr,
  input  logic [width-1:0] i_riscv_stbuf_data,
  input  logic [1:0]       i_riscv_stbuf_size,
  output logic             o_riscv_stbuf_stall,
  output logic             o_riscv_stbuf_misaligned,
  output logic             o_riscv_stbuf_req,
  output logic [width-1:0] o_riscv_stbuf_waddr,
  output logic [width-1:0] o_riscv_stbuf_wdata,
  output logic [7:0]       o_riscv_stbuf_wstrb,
  input  logic             i_riscv_stbuf_ack,
  input  logic             i_riscv_stbuf_ldvalid,
  input  logic [width-1:0] i_riscv_stbuf_ldaddr,
  output logic             o_riscv_stbuf_ldconflict,
  output logic             o_riscv_stbuf_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]                  r_wrptr, r_rdptr;
  logic [AW:0]                    r_count;
  logic [DEPTH-1:0]               r_vld;
  logic [DEPTH-1:0][width-1:0]    r_addr, r_data;
  logic [DEPTH-1:0][7:0]          r_strb;

  logic [2:0]       w_off;
  logic             w_mis, w_full, w_empty, w_enq, w_deq;
  logic [7:0]       w_strb;
  logic [width-1:0] w_mask, w_data, w_dwaddr, w_lddw;
  logic [DEPTH-1:0] w_hit;
  logic             w_unused;

  assign w_off    = i_riscv_stbuf_addr[2:0];
  assign w_dwaddr = {i_riscv_stbuf_addr[width-1:3], 3'b000};
  assign w_lddw   = {i_riscv_stbuf_ldaddr[width-1:3], 3'b000};
  assign w_unused = ^i_riscv_stbuf_ldaddr[2:0];

  always_comb begin
    w_mis  = 1'b0;
    w_strb = 8'hFF;
    w_mask = '1;
    case (i_riscv_stbuf_size)
      2'b00: begin w_strb = 8'h01 << w_off; w_mask = 64'h0000_0000_0000_00FF; end
      2'b01: begin w_mis = w_off[0];    w_strb = 8'h03 << w_off; w_mask = 64'h0000_0000_0000_FFFF; end
      2'b10: begin w_mis = |w_off[1:0]; w_strb = 8'h0F << w_off; w_mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin w_mis = |w_off; w_strb = 8'hFF; w_mask = '1; end
    endcase
  end

  // Bits shifted past the top of the doubleword are dropped by truncation.
  assign w_data  = (i_riscv_stbuf_data & w_mask) << {w_off, 3'b000};

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full is taken from the registered count, so a same-cycle ack never frees a slot early.
  assign w_enq   = i_riscv_stbuf_valid & ~w_mis & ~w_full;
  assign w_deq   = i_riscv_stbuf_ack & ~w_empty;

  always_ff @(posedge i_riscv_stbuf_clk) begin
    if (i_riscv_stbuf_rst) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_enq) begin
        r_addr[r_wrptr] <= w_dwaddr;
        r_data[r_wrptr] <= w_data;
        r_strb[r_wrptr] <= w_strb;
        r_vld[r_wrptr]  <= 1'b1;
        r_wrptr         <= r_wrptr + 1'b1;
      end
      if (w_deq) begin
        r_vld[r_rdptr] <= 1'b0;
        r_rdptr        <= r_rdptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_hit[g] = r_vld[g] & (r_addr[g] == w_lddw);
  end

  assign o_riscv_stbuf_misaligned = i_riscv_stbuf_valid & w_mis;
  assign o_riscv_stbuf_stall      = i_riscv_stbuf_valid & w_full & ~w_mis;
  assign o_riscv_stbuf_req        = ~w_empty;
  assign o_riscv_stbuf_empty      = w_empty;
  // Head fields are gated by the entry valid so stale storage reads as zero after reset.
  assign o_riscv_stbuf_waddr      = r_vld[r_rdptr] ? r_addr[r_rdptr] : '0;
  assign o_riscv_stbuf_wdata      = r_vld[r_rdptr] ? r_data[r_rdptr] : '0;
  assign o_riscv_stbuf_wstrb      = r_vld[r_rdptr] ? r_strb[r_rdptr] : '0;
  assign o_riscv_stbuf_ldconflict = i_riscv_stbuf_ldvalid & |w_hit;
endmodule

// File: tb/tb_riscv_storebuffer.sv
// Bench for riscv_storebuffer: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the store buffer.
module tb_riscv_storebuffer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, valid, ack, ldv;
  logic [63:0] addr, data, ldaddr;
  logic [1:0]  size;
  logic        stall, mis, req, ldc, empty;
  logic [63:0] waddr, wdata;
  logic [7:0]  wstrb;

  riscv_storebuffer #(.width(64), .DEPTH(D)) dut (
    .i_riscv_stbuf_clk(clk), .i_riscv_stbuf_rst(rst),
    .i_riscv_stbuf_valid(valid), .i_riscv_stbuf_addr(addr),
    .i_riscv_stbuf_data(data), .i_riscv_stbuf_size(size),
    .o_riscv_stbuf_stall(stall), .o_riscv_stbuf_misaligned(mis),
    .o_riscv_stbuf_req(req), .o_riscv_stbuf_waddr(waddr),
    .o_riscv_stbuf_wdata(wdata), .o_riscv_stbuf_wstrb(wstrb),
    .i_riscv_stbuf_ack(ack), .i_riscv_stbuf_ldvalid(ldv),
    .i_riscv_stbuf_ldaddr(ldaddr), .o_riscv_stbuf_ldconflict(ldc),
    .o_riscv_stbuf_empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [63:0] d; logic [7:0] s; } ent_t;
  ent_t q[$];
  int n_chk = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit m_mis(logic [63:0] a, logic [1:0] s);
    return (int'(a[2:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [7:0] m_strb(logic [63:0] a, logic [1:0] s);
    logic [7:0] r = '0;
    int off = int'(a[2:0]);
    for (int j = 0; j < nbytes(s); j++)
      if (off + j < 8) r[off+j] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_data(logic [63:0] a, logic [63:0] dv, logic [1:0] s);
    logic [63:0] r = '0;
    int off = int'(a[2:0]);
    for (int j = 0; j < nbytes(s); j++)
      if (off + j < 8) r[(off+j)*8 +: 8] = dv[j*8 +: 8];
    return r;
  endfunction

  task automatic drv(bit r, bit v, logic [63:0] a, logic [63:0] dv, logic [1:0] s,
                     bit k, bit lv, logic [63:0] la);
    rst = r; valid = v; addr = a; data = dv; size = s; ack = k; ldv = lv; ldaddr = la;
  endtask

  // Sample on the falling edge and compare every output with the model.
  task automatic check_now();
    bit e_mis, e_ldc;
    @(negedge clk);
    e_mis = valid && m_mis(addr, size);
    e_ldc = 1'b0;
    foreach (q[i]) if (ldv && q[i].a == {ldaddr[63:3], 3'b000}) e_ldc = 1'b1;
    chk("misaligned", 64'(mis), 64'(e_mis));
    chk("stall", 64'(stall), 64'(valid && !e_mis && q.size() == D));
    chk("req", 64'(req), 64'(q.size() != 0));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("waddr", waddr, q.size() != 0 ? q[0].a : 64'h0);
    chk("wdata", wdata, q.size() != 0 ? q[0].d : 64'h0);
    chk("wstrb", 64'(wstrb), q.size() != 0 ? 64'(q[0].s) : 64'h0);
    chk("ldconflict", 64'(ldc), 64'(e_ldc));
  endtask

  task automatic adv();
    bit full, deq, enq;
    ent_t e;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      full = (q.size() == D);
      deq  = ack && q.size() != 0;
      enq  = valid && !m_mis(addr, size) && !full;
      if (deq) void'(q.pop_front());
      if (enq) begin
        e.a = {addr[63:3], 3'b000};
        e.d = m_data(addr, data, size);
        e.s = m_strb(addr, size);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic run(bit r, bit v, logic [63:0] a, logic [63:0] dv, logic [1:0] s,
                     bit k, bit lv, logic [63:0] la);
    drv(r, v, a, dv, s, k, lv, la);
    check_now();
    adv();
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    adv();
    adv();
    // Reset state
    run(0, 0, 0, 0, 0, 0, 0, 0);
    // 1: SB at 0x1003
    run(0, 1, 64'h1003, 64'hAB, 2'b00, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    check_now();
    chk("t1_req", 64'(req), 64'h1);
    chk("t1_waddr", waddr, 64'h1000);
    chk("t1_wstrb", 64'(wstrb), 64'h08);
    chk("t1_wdata", wdata, 64'h0000_0000_AB00_0000);
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    check_now();
    chk("t1_empty", 64'(empty), 64'h1);
    adv();
    // 2: misaligned SH, then aligned SD
    drv(0, 1, 64'h2001, 64'h55, 2'b01, 0, 0, 0);
    check_now();
    chk("t2_mis", 64'(mis), 64'h1);
    adv();
    drv(0, 1, 64'h2008, 64'h1122_3344_5566_7788, 2'b11, 0, 0, 0);
    check_now();
    chk("t2_req_low", 64'(req), 64'h0);
    adv();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    check_now();
    chk("t2_wstrb", 64'(wstrb), 64'hFF);
    chk("t2_wdata", wdata, 64'h1122_3344_5566_7788);
    adv();
    // 3: fill with SW, fifth stalls, one ack frees a slot a cycle later
    for (int i = 0; i < 4; i++) run(0, 1, 64'h5000 + 64'(i*8) + 4, 64'(i+1), 2'b10, 0, 0, 0);
    drv(0, 1, 64'h5024, 64'h5, 2'b10, 0, 0, 0);
    check_now();
    chk("t3_stall", 64'(stall), 64'h1);
    adv();
    drv(0, 1, 64'h5024, 64'h5, 2'b10, 1, 0, 0);
    check_now();
    chk("t3_stall_ack", 64'(stall), 64'h1);
    adv();
    drv(0, 1, 64'h5024, 64'h5, 2'b10, 0, 0, 0);
    check_now();
    chk("t3_accept", 64'(stall), 64'h0);
    adv();
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 0);
      check_now();
      chk("t3_order", waddr, 64'h5008 + 64'(i*8));
      adv();
    end
    run(0, 0, 0, 0, 0, 0, 0, 0);
    // 4: one pending, concurrent enqueue+ack wraps pointers twice
    run(0, 1, 64'h6000, 64'h77, 2'b11, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      drv(0, 1, 64'h6000 + 64'(i*8), 64'(i*64'h0101_0101), 2'b11, 1, 0, 0);
      check_now();
      chk("t4_count1", 64'(q.size()), 64'h1);
      adv();
    end
    run(0, 0, 0, 0, 0, 1, 0, 0);
    // 5: load conflict against a pending SW
    run(0, 1, 64'h3004, 64'hDEAD_BEEF, 2'b10, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 64'h3000);
    check_now(); chk("t5_hit", 64'(ldc), 64'h1); adv();
    drv(0, 0, 0, 0, 0, 0, 1, 64'h3008);
    check_now(); chk("t5_miss", 64'(ldc), 64'h0); adv();
    drv(0, 0, 0, 0, 0, 1, 1, 64'h3000);
    check_now(); chk("t5_hit_ackcyc", 64'(ldc), 64'h1); adv();
    drv(0, 0, 0, 0, 0, 0, 1, 64'h3000);
    check_now(); chk("t5_after_ack", 64'(ldc), 64'h0); adv();
    // 6: reset with three pending entries and ack high
    for (int i = 0; i < 3; i++) run(0, 1, 64'h7000 + 64'(i*8), 64'(i), 2'b11, 0, 0, 0);
    run(1, 1, 64'h7100, 64'h9, 2'b11, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 1, 64'h7000);
    check_now();
    chk("t6_req", 64'(req), 64'h0);
    chk("t6_empty", 64'(empty), 64'h1);
    chk("t6_ldc", 64'(ldc), 64'h0);
    adv();
    for (int i = 0; i < 3; i++) run(0, 0, 0, 0, 0, 1, 0, 0);
    // Random traffic in a small address window to provoke conflicts and wrap
    for (int i = 0; i < 600; i++)
      run($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
          64'h4000 + 64'($urandom_range(0, 47)), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
          64'h4000 + 64'($urandom_range(0, 47)));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_storebuffer.md
Name: riscv_storebuffer

Overview:
- Write-side counterpart of the memory-stage load extender.
- Accepts committed store requests from the memory stage.
- Per request: checks alignment, shifts store data into doubleword lanes, generates byte write strobes, and queues the result in a small FIFO.
- Drains the FIFO to the data-memory write port over a req/ack handshake.
- Flags loads that hit a pending store so the hazard unit can stall them.

Parameters:
- width, 64, data/address width (only 64 is supported).
- DEPTH, 4, number of store-buffer entries (power of 2, at least 2).

Ports:
- i_riscv_stbuf_clk  in  1  clock.
- i_riscv_stbuf_rst  in  1  reset, synchronous, active-high.
- i_riscv_stbuf_valid  in  1  store request from memory stage.
- i_riscv_stbuf_addr  in  width  byte address of store.
- i_riscv_stbuf_data  in  width  unshifted store data (rs2).
- i_riscv_stbuf_size  in  2  00 SB, 01 SH, 10 SW, 11 SD (funct3[1:0]).
- o_riscv_stbuf_stall  out  1  buffer full; request not accepted.
- o_riscv_stbuf_misaligned  out  1  store address misaligned (to CSR trap logic).
- o_riscv_stbuf_req  out  1  memory write request.
- o_riscv_stbuf_waddr  out  width  doubleword-aligned address {addr[63:3],3'b000}.
- o_riscv_stbuf_wdata  out  width  lane-shifted write data.
- o_riscv_stbuf_wstrb  out  8  byte write enables.
- i_riscv_stbuf_ack  in  1  memory accepted the head entry.
- i_riscv_stbuf_ldvalid  in  1  load in memory stage.
- i_riscv_stbuf_ldaddr  in  width  load byte address.
- o_riscv_stbuf_ldconflict  out  1  load hits a pending store.
- o_riscv_stbuf_empty  out  1  no pending stores (used by FENCE).

Behaviour:
- Reset (synchronous, active-high): write pointer, read pointer, count and all entry valid bits are cleared. o_req=0, o_empty=1, o_stall=0, o_waddr/o_wdata/o_wstrb=0. Reset overrides a same-cycle request or ack. Any in-flight entry is discarded.
- Alignment check (combinational):
  - SB: always aligned.
  - SH: misaligned if addr[0]≠0.
  - SW: misaligned if addr[1:0]≠0.
  - SD: misaligned if addr[2:0]≠0.
  - o_misaligned = valid & misaligned, independent of full.
  - A misaligned request is never enqueued.
- Strobe generation, with off = addr[2:0]:
  - SB: 8'h01<<off.
  - SH: 8'h03<<off.
  - SW: 8'h0F<<off.
  - SD: 8'hFF.
- Data generation: the low 8/16/32/64 bits of data (per size) are zero-extended, then shifted left by off*8 and truncated to 64 bits.
- Enqueue: on a clock edge with valid & ~misaligned & ~full, store {dword address, shifted data, strobe} at the write pointer; wrptr++ and count++.
- Full:
  - o_stall = valid & full & ~misaligned (combinational).
  - Full blocks enqueue even when an ack arrives in the same cycle (no bypass). The request is accepted one cycle later.
- Dequeue:
  - o_req = ~empty.
  - o_waddr/o_wdata/o_wstrb show the head entry and stay stable while o_req=1 and ack=0.
  - On an edge with req & ack: rdptr++ and count--.
  - An ack while empty is ignored.
- Simultaneous enqueue and dequeue (not full, not empty): both pointers advance and count is unchanged.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits. full = (count==DEPTH). empty = (count==0).
- Latency: an accepted store appears on o_req on the cycle after acceptance if the buffer was empty. Otherwise it is FIFO-ordered behind older entries.
- Load conflict (combinational): o_ldconflict = ldvalid & (any valid entry whose address equals {ldaddr[63:3],3'b000}). The head entry is included until the cycle its ack is registered. There is no forwarding; a conflicting load must stall.
- o_empty = (count==0), registered-derived.

Test Plan:
1. Reset, then SB addr=0x1003 data=0xAB → next cycle o_req=1, waddr=0x1000, wstrb=0x08, wdata=0x00000000AB000000. Ack → o_empty=1.
2. SH addr=0x2001 → o_misaligned=1, count unchanged, o_req stays 0. SD addr=0x2008 data=0x1122334455667788 → wstrb=0xFF, wdata unchanged.
3. Five SW stores with ack held low → entries 1–4 accepted, fifth gives o_stall=1. Ack one → fifth accepted the following cycle, and order is preserved on drain.
4. Steady state with one entry pending: enqueue and ack in the same cycle → count stays 1 and the next head is the new entry. Wrap the pointers past DEPTH twice and check data integrity.
5. Pending SW at 0x3004, load ldaddr=0x3000 → o_ldconflict=1. Load 0x3008 → 0. After ack of 0x3004 → 0.
6. Assert reset with 3 entries pending and ack high → next cycle o_req=0, o_empty=1, and the dropped entries never reappear.
